// File: rtl/fsb_pkg.sv
// fsb_pkg: shared types and widths for the front-side bus cycle sequencer
package fsb_pkg;
  localparam int WS_W = 4;
  localparam int TMO_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_REFRESH, S_DECODE, S_RAM, S_ROM, S_IO, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {PATH_RAM, PATH_ROM, PATH_IO, PATH_IACK} path_t;
  function automatic path_t sel_path(input logic [3:0] sel);
    return sel[0] ? PATH_RAM : sel[1] ? PATH_ROM : sel[2] ? PATH_IO : PATH_IACK;
  endfunction
endpackage

// File: rtl/fsb_waitctr.sv
// fsb_waitctr: loadable down-counter with zero flag for wait-state timing
module fsb_waitctr import fsb_pkg::*; #(
  parameter int W = WS_W
) (
  input  logic         FCLK,
  input  logic         RESET,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge FCLK)
    if (RESET) cnt <= '0;
    else if (load) cnt <= din;
    else if (dec && !zero) cnt <= cnt - W'(1);
endmodule

// File: rtl/fsb_cycle_ctl.sv
// fsb_cycle_ctl: schedules 68000 bus cycles onto RAM/ROM/IO/IACK and arbitrates DRAM refresh
module fsb_cycle_ctl import fsb_pkg::*; #(
  parameter int RAM_WS  = 2,
  parameter int ROM_WS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic FCLK,
  input  logic RESET,
  input  logic BACT,
  input  logic RAMCS,
  input  logic ROMCS,
  input  logic IOCS,
  input  logic IACS,
  input  logic RefReq,
  input  logic RefDone,
  output logic RefGnt,
  input  logic IOAck,
  output logic IOReq,
  output logic Ready0,
  output logic Ready1,
  output logic Ready2,
  output logic BERR0,
  output logic BERR1
);
  state_t st, ns;
  path_t path;
  logic [3:0] sel;
  logic [TMO_W-1:0] tmo;
  logic wzero, run, tmo_hit;
  assign sel = {IACS, IOCS, ROMCS, RAMCS};
  assign path = sel_path(sel);
  assign run = st inside {S_DECODE, S_RAM, S_ROM, S_IO};
  assign tmo_hit = tmo >= TMO_W'(TIMEOUT - 1);
  // loaded with WS-1 on DECODE exit so DONE lands exactly WS cycles after dispatch
  fsb_waitctr #(.W(WS_W)) u_wait (
    .FCLK (FCLK),
    .RESET(RESET),
    .load (st == S_DECODE),
    .dec  (st == S_RAM || st == S_ROM),
    .din  (path == PATH_ROM ? WS_W'(ROM_WS - 1) : WS_W'(RAM_WS - 1)),
    .zero (wzero)
  );
  always_comb begin
    ns = st;
    case (st)
      S_IDLE:    ns = RefReq ? S_REFRESH : BACT ? S_DECODE : S_IDLE;
      S_REFRESH: ns = RefDone ? S_IDLE : S_REFRESH;
      S_DECODE:  ns = !BACT ? S_IDLE : !$onehot(sel) ? S_ERR : path == PATH_IO ? S_IO :
                      path == PATH_IACK ? S_DONE : path == PATH_RAM ? (RAM_WS == 0 ? S_DONE : S_RAM) :
                      (ROM_WS == 0 ? S_DONE : S_ROM);
      S_RAM, S_ROM: ns = !BACT ? S_IDLE : wzero ? S_DONE : tmo_hit ? S_ERR : st;
      S_IO:      ns = !BACT ? S_IDLE : IOAck ? S_DONE : tmo_hit ? S_ERR : S_IO;
      default:   ns = BACT ? st : S_IDLE;
    endcase
  end
  // outputs are registered images of the next state; the non-owning Ready leads from DECODE exit
  always_ff @(posedge FCLK)
    if (RESET) begin
      st <= S_IDLE;
      tmo <= '0;
      RefGnt <= 1'b0;
      IOReq <= 1'b0;
      Ready0 <= 1'b0;
      Ready1 <= 1'b0;
      Ready2 <= 1'b0;
      BERR0 <= 1'b0;
      BERR1 <= 1'b0;
    end else begin
      st <= ns;
      tmo <= !run ? '0 : &tmo ? tmo : tmo + TMO_W'(1);
      RefGnt <= ns == S_REFRESH;
      IOReq <= ns == S_IO;
      Ready0 <= ns == S_DONE || ns == S_IO;
      Ready1 <= ns == S_DONE || ns == S_RAM || ns == S_ROM;
      Ready2 <= ns inside {S_DECODE, S_RAM, S_ROM, S_IO, S_DONE};
      BERR0 <= ns == S_ERR && (st == S_ERR ? BERR0 : st != S_DECODE);
      BERR1 <= ns == S_ERR && (st == S_ERR ? BERR1 : st == S_DECODE);
    end
endmodule

// File: tb/tb_fsb_cycle_ctl.sv
// tb_fsb_cycle_ctl: directed checks of the bus cycle sequencer; o = {RefGnt,IOReq,Ready0,Ready1,Ready2,BERR0,BERR1}
module tb_fsb_cycle_ctl;
  logic FCLK = 0, RESET = 1, BACT = 0, RAMCS = 0, ROMCS = 0, IOCS = 0, IACS = 0;
  logic RefReq = 0, RefDone = 0, IOAck = 0;
  logic RefGnt, IOReq, Ready0, Ready1, Ready2, BERR0, BERR1;
  logic [6:0] o;
  int vectors = 0, miscompares = 0;
  assign o = {RefGnt, IOReq, Ready0, Ready1, Ready2, BERR0, BERR1};
  localparam logic [6:0] IDLE = 7'b0000000, DEC = 7'b0000100, MEMW = 7'b0001100, IOW = 7'b0110100;
  localparam logic [6:0] DONE = 7'b0011100, REF = 7'b1000000, E0 = 7'b0000010, E1 = 7'b0000001;
  fsb_cycle_ctl #(.RAM_WS(2), .ROM_WS(4), .TIMEOUT(255)) dut (
    .FCLK(FCLK), .RESET(RESET), .BACT(BACT), .RAMCS(RAMCS), .ROMCS(ROMCS), .IOCS(IOCS), .IACS(IACS),
    .RefReq(RefReq), .RefDone(RefDone), .RefGnt(RefGnt), .IOAck(IOAck), .IOReq(IOReq),
    .Ready0(Ready0), .Ready1(Ready1), .Ready2(Ready2), .BERR0(BERR0), .BERR1(BERR1)
  );
  always #5 FCLK = ~FCLK;
  task automatic step();
    @(posedge FCLK);
    #1;
  endtask
  task automatic test_reset();
    RESET = 1;
    BACT = 1;
    RAMCS = 1;
    RefReq = 1;
    repeat (3) step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL reset got %b want %b", o, IDLE); end
    BACT = 0;
    RAMCS = 0;
    RefReq = 0;
    RESET = 0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL reset_release got %b want %b", o, IDLE); end
  endtask
  task automatic test_ram();
    logic [6:0] exp [5] = '{DEC, MEMW, MEMW, DONE, DONE};
    BACT = 1;
    RAMCS = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (o !== exp[i]) begin miscompares++; $display("FAIL ram_seq[%0d] got %b want %b", i, o, exp[i]); end
    end
    BACT = 0;
    RAMCS = 0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL ram_release got %b want %b", o, IDLE); end
  endtask
  task automatic test_io();
    BACT = 1;
    IOCS = 1;
    step();
    vectors++;
    if (o !== DEC) begin miscompares++; $display("FAIL io_decode got %b want %b", o, DEC); end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (o !== IOW) begin miscompares++; $display("FAIL io_wait[%0d] got %b want %b", i, o, IOW); end
    end
    IOAck = 1;
    step();
    vectors++;
    if (o !== DONE) begin miscompares++; $display("FAIL io_ack got %b want %b", o, DONE); end
    IOAck = 0;
    BACT = 0;
    IOCS = 0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL io_release got %b want %b", o, IDLE); end
  endtask
  task automatic test_refresh();
    RefReq = 1;
    BACT = 1;
    ROMCS = 1;
    step();
    vectors++;
    if (o !== REF) begin miscompares++; $display("FAIL ref_grant got %b want %b", o, REF); end
    RefReq = 0;
    repeat (2) begin
      step();
      vectors++;
      if (o !== REF) begin miscompares++; $display("FAIL ref_hold got %b want %b", o, REF); end
    end
    RefDone = 1;
    step();
    RefDone = 0;
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL ref_done got %b want %b", o, IDLE); end
    step();
    vectors++;
    if (o !== DEC) begin miscompares++; $display("FAIL ref_decode got %b want %b", o, DEC); end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (o !== MEMW) begin miscompares++; $display("FAIL rom_wait[%0d] got %b want %b", i, o, MEMW); end
    end
    step();
    vectors++;
    if (o !== DONE) begin miscompares++; $display("FAIL rom_done got %b want %b", o, DONE); end
    BACT = 0;
    ROMCS = 0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL rom_release got %b want %b", o, IDLE); end
  endtask
  task automatic test_decode(input logic [3:0] s, input logic [6:0] want, input string nm);
    {IACS, IOCS, ROMCS, RAMCS} = s;
    BACT = 1;
    step();
    vectors++;
    if (o !== DEC) begin miscompares++; $display("FAIL %s_decode got %b want %b", nm, o, DEC); end
    repeat (2) begin
      step();
      vectors++;
      if (o !== want) begin miscompares++; $display("FAIL %s_result got %b want %b", nm, o, want); end
    end
    BACT = 0;
    {IACS, IOCS, ROMCS, RAMCS} = 4'b0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL %s_release got %b want %b", nm, o, IDLE); end
  endtask
  task automatic test_timeout(input logic ack_on_edge);
    logic [6:0] want;
    want = ack_on_edge ? DONE : E0;
    BACT = 1;
    IOCS = 1;
    step();
    vectors++;
    if (o !== DEC) begin miscompares++; $display("FAIL tmo_decode got %b want %b", o, DEC); end
    for (int i = 1; i < 255; i++) begin
      step();
      vectors++;
      if (o !== IOW) begin miscompares++; $display("FAIL tmo_wait[%0d] got %b want %b", i, o, IOW); end
    end
    IOAck = ack_on_edge;
    step();
    IOAck = 0;
    vectors++;
    if (o !== want) begin miscompares++; $display("FAIL tmo_edge ack=%0b got %b want %b", ack_on_edge, o, want); end
    step();
    vectors++;
    if (o !== want) begin miscompares++; $display("FAIL tmo_hold ack=%0b got %b want %b", ack_on_edge, o, want); end
    BACT = 0;
    IOCS = 0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL tmo_release got %b want %b", o, IDLE); end
  endtask
  task automatic test_abort();
    BACT = 1;
    IOCS = 1;
    repeat (3) step();
    vectors++;
    if (o !== IOW) begin miscompares++; $display("FAIL abort_io got %b want %b", o, IOW); end
    BACT = 0;
    IOCS = 0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL abort_idle got %b want %b", o, IDLE); end
    IOAck = 1;
    repeat (2) begin
      step();
      vectors++;
      if (o !== IDLE) begin miscompares++; $display("FAIL abort_late_ack got %b want %b", o, IDLE); end
    end
    IOAck = 0;
    RefReq = 1;
    step();
    vectors++;
    if (o !== REF) begin miscompares++; $display("FAIL rst_ref_grant got %b want %b", o, REF); end
    RESET = 1;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL rst_in_refresh got %b want %b", o, IDLE); end
    RESET = 0;
    RefReq = 0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL rst_after got %b want %b", o, IDLE); end
  endtask
  task automatic test_back_to_back();
    logic [6:0] exp [4] = '{DEC, MEMW, MEMW, DONE};
    BACT = 1;
    RAMCS = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      RefReq = 1;
      vectors++;
      if (o !== exp[i]) begin miscompares++; $display("FAIL b2b_seq[%0d] got %b want %b", i, o, exp[i]); end
    end
    BACT = 0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL b2b_idle got %b want %b", o, IDLE); end
    BACT = 1;
    step();
    vectors++;
    if (o !== REF) begin miscompares++; $display("FAIL b2b_pending_ref got %b want %b", o, REF); end
    RefReq = 0;
    RefDone = 1;
    step();
    RefDone = 0;
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL b2b_ref_done got %b want %b", o, IDLE); end
    step();
    vectors++;
    if (o !== DEC) begin miscompares++; $display("FAIL b2b_decode got %b want %b", o, DEC); end
    BACT = 0;
    RAMCS = 0;
    step();
    vectors++;
    if (o !== IDLE) begin miscompares++; $display("FAIL b2b_abort got %b want %b", o, IDLE); end
  endtask
  initial begin
    test_reset();
    test_ram();
    test_io();
    test_refresh();
    test_decode(4'b0000, E1, "nosel");
    test_decode(4'b0101, E1, "multisel");
    test_decode(4'b1000, DONE, "iack");
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
